// File: rtl/mux_sel_arbiter_if.sv
// Arbiter-to-mux bus: channel requests and release in, owner select and grant out.
// The master modport is the side that issues requests (the requesting channels or a bench);
// the slave modport is the arbiter itself.
interface mux_sel_arbiter_if;
  logic [3:0] req_in;
  logic       done_in;
  logic [1:0] sel_out;
  logic [3:0] grant_out;
  logic       valid_out;
  logic       timeout_out;

  modport master (
    output req_in,
    output done_in,
    input  sel_out,
    input  grant_out,
    input  valid_out,
    input  timeout_out
  );

  modport slave (
    input  req_in,
    input  done_in,
    output sel_out,
    output grant_out,
    output valid_out,
    output timeout_out
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin 4-channel arbiter driving the select of a downstream 4:1 mux.
// An owner keeps the select until it releases (done), withdraws its request,
// or reaches the hold limit. On release the next owner is chosen on the same
// edge, with the released channel at lowest priority. All outputs are registered.
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  mux_sel_arbiter_if.slave   bus
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam bit               TIMEOUT_EN = (MAX_HOLD != 0);

  // Round-robin search starting after 'last'; result is {found, index}.
  // The candidate at offset 4 wraps back to 'last' itself, so it is tried last.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!res[2] && req[cand]) begin
        res = {1'b1, cand};
      end
    end
    return res;
  endfunction

  // Binary channel index to one-hot grant vector.
  function automatic logic [3:0] to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       grant_q, grant_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;

  logic [2:0]       idle_pick_s;
  logic [2:0]       rel_pick_s;
  logic             rel_done_s;
  logic             rel_drop_s;
  logic             rel_limit_s;
  logic             release_s;
  logic             forced_s;

  // Release decision for the current owner and the candidate winners for both states.
  always_comb begin
    idle_pick_s = rr_pick(bus.req_in, last_q);
    rel_pick_s  = rr_pick(bus.req_in, sel_q);
    rel_done_s  = bus.done_in;
    rel_drop_s  = !bus.req_in[sel_q];
    rel_limit_s = TIMEOUT_EN && (cnt_q == HOLD_LIMIT);
    release_s   = rel_done_s || rel_drop_s || rel_limit_s;
    // Timeout is flagged only when neither higher-priority release reason applies.
    forced_s    = rel_limit_s && !rel_done_s && !rel_drop_s;
  end

  // Next-state and output logic; timeout is a single-cycle pulse, so it defaults low.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    last_d    = last_q;
    case (state_q)
      ST_IDLE: begin
        if (idle_pick_s[2]) begin
          state_d = ST_GRANT;
          sel_d   = idle_pick_s[1:0];
          grant_d = to_onehot(idle_pick_s[1:0]);
          valid_d = 1'b1;
          cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          valid_d = 1'b0;
          grant_d = 4'b0000;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          last_d    = sel_q;
          timeout_d = forced_s;
          if (rel_pick_s[2]) begin
            // Back-to-back handover (possibly to the same channel) restarts the hold count.
            sel_d   = rel_pick_s[1:0];
            grant_d = to_onehot(rel_pick_s[1:0]);
            valid_d = 1'b1;
            cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            // No requester left: drop the grant but keep sel so the mux output stays steady.
            state_d = ST_IDLE;
            valid_d = 1'b0;
            grant_d = 4'b0000;
            cnt_d   = {CNT_W{1'b0}};
          end
        end else begin
          // Owner retained: count up, saturating so the counter never wraps.
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = cnt_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        grant_d = 4'b0000;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous active-low reset; last=3 makes ch0 first.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_IDLE;
      sel_q     <= 2'd0;
      grant_q   <= 4'b0000;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
      last_q    <= 2'd3;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
    end
  end

  assign bus.sel_out     = sel_q;
  assign bus.grant_out   = grant_q;
  assign bus.valid_out   = valid_q;
  assign bus.timeout_out = timeout_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: directed test-plan steps followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_mux_sel_arbiter;
  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 4;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  // Behavioural model state: who owns, for how many cycles, who owned last.
  bit   m_valid;
  int   m_sel;
  int   m_last;
  int   m_held;
  bit   m_to;

  mux_sel_arbiter_if bus_if ();

  mux_sel_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one clock edge of the arbitration rules to the model.
  task automatic model_update();
    logic [3:0] req;
    bit         rel;
    req = bus_if.req_in;
    if (!rst_n) begin
      m_valid = 1'b0; m_sel = 0; m_last = 3; m_held = 0; m_to = 1'b0;
      return;
    end
    m_to = 1'b0;
    rel  = 1'b0;
    if (m_valid) begin
      if (bus_if.done_in) rel = 1'b1;
      else if (!req[m_sel]) rel = 1'b1;
      else if (MAX_HOLD > 0 && m_held == MAX_HOLD) begin
        rel  = 1'b1;
        m_to = 1'b1;
      end
      if (rel) begin
        m_last  = m_sel;
        m_valid = 1'b0;
      end else begin
        m_held = m_held + 1;
      end
    end
    if (!m_valid && req != 4'b0000 && (rel || m_held >= 0)) begin
      for (int k = 1; k <= 4; k++) begin
        if (!m_valid && req[(m_last + k) % 4]) begin
          m_sel   = (m_last + k) % 4;
          m_valid = 1'b1;
          m_held  = 1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Compare all four outputs against the model.
  task automatic check(input string tag);
    logic [3:0] exp_grant;
    logic [1:0] exp_sel;
    exp_sel   = 2'(m_sel);
    exp_grant = m_valid ? (4'b0001 << exp_sel) : 4'b0000;
    tests++;
    assert (bus_if.sel_out === exp_sel) else begin
      fails++; $error("FAIL %s sel_out: got %0d expected %0d", tag, bus_if.sel_out, exp_sel);
    end
    tests++;
    assert (bus_if.grant_out === exp_grant) else begin
      fails++; $error("FAIL %s grant_out: got %b expected %b", tag, bus_if.grant_out, exp_grant);
    end
    tests++;
    assert (bus_if.valid_out === m_valid) else begin
      fails++; $error("FAIL %s valid_out: got %b expected %b", tag, bus_if.valid_out, m_valid);
    end
    tests++;
    assert (bus_if.timeout_out === m_to) else begin
      fails++; $error("FAIL %s timeout_out: got %b expected %b", tag, bus_if.timeout_out, m_to);
    end
  endtask

  // Directed check of an observed 4-bit value against a literal from the test plan.
  task automatic expect4(input string tag, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++; $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(); check("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0; fails = 0;
    m_valid = 1'b0; m_sel = 0; m_last = 3; m_held = 0; m_to = 1'b0;
    rst_n = 1'b0;
    bus_if.req_in  = 4'b1111;
    bus_if.done_in = 1'b0;

    // Reset held 3 cycles with all channels requesting.
    for (int i = 0; i < 3; i++) begin
      step(); check("reset_hold");
      expect4("reset_valid", {3'b000, bus_if.valid_out}, 4'b0000);
    end
    rst_n = 1'b1;
    step(); check("first_grant");
    expect4("first_grant_onehot", bus_if.grant_out, 4'b0001);

    // Rotation: done every grant cycle walks 1,2,3,0.
    bus_if.done_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(); check("rotate");
      expect4("rotate_sel", {2'b00, bus_if.sel_out}, 4'(i % 4));
      expect4("rotate_to", {3'b000, bus_if.timeout_out}, 4'b0000);
    end
    bus_if.done_in = 1'b0;

    // Timeout: ch0 held MAX_HOLD cycles, then ch2 with a timeout pulse.
    do_reset();
    bus_if.req_in = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      step(); check("hold_ch0");
      expect4("hold_ch0_grant", bus_if.grant_out, 4'b0001);
    end
    step(); check("timeout_handover");
    expect4("timeout_handover_grant", bus_if.grant_out, 4'b0100);
    expect4("timeout_pulse", {3'b000, bus_if.timeout_out}, 4'b0001);
    step(); check("timeout_one_cycle");
    expect4("timeout_cleared", {3'b000, bus_if.timeout_out}, 4'b0000);

    // Only ch0 requesting: ch2 withdraws, ch0 is granted then re-granted on timeout.
    bus_if.req_in = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step(); check("solo_ch0");
    end
    expect4("solo_regrant_grant", bus_if.grant_out, 4'b0001);
    expect4("solo_regrant_to", {3'b000, bus_if.timeout_out}, 4'b0001);

    // Done coincides with the hold limit: plain release, no timeout.
    for (int i = 0; i < 3; i++) begin
      step(); check("to_done_hold");
    end
    bus_if.done_in = 1'b1;
    step(); check("done_at_limit");
    expect4("done_at_limit_to", {3'b000, bus_if.timeout_out}, 4'b0000);
    bus_if.done_in = 1'b0;

    // Withdrawal to idle keeps sel, then re-grant of ch1.
    do_reset();
    bus_if.req_in = 4'b0010;
    step(); check("grant_ch1");
    bus_if.req_in = 4'b0000;
    step(); check("withdraw_idle");
    expect4("idle_sel_kept", {2'b00, bus_if.sel_out}, 4'd1);
    expect4("idle_grant", bus_if.grant_out, 4'b0000);
    step(); check("idle_stay");
    bus_if.req_in = 4'b0010;
    step(); check("regrant_ch1");
    expect4("regrant_ch1_grant", bus_if.grant_out, 4'b0010);

    // Reset mid-grant of ch3, then arbitration restarts at ch0.
    do_reset();
    bus_if.req_in = 4'b1000;
    step(); check("grant_ch3");
    step(); check("ch3_cnt2");
    rst_n = 1'b0;
    step(); check("mid_reset");
    expect4("mid_reset_grant", bus_if.grant_out, 4'b0000);
    rst_n = 1'b1;
    bus_if.req_in = 4'b1111;
    step(); check("restart_ch0");
    expect4("restart_ch0_grant", bus_if.grant_out, 4'b0001);

    // Randomized traffic with sticky requests, random done and rare resets.
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 3) == 0) bus_if.req_in = 4'($urandom);
      bus_if.done_in = ($urandom_range(0, 4) == 0);
      step(); check("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
